// File: rtl/prog_mem.sv
// Instruction memory with a byte-serial little-endian program loader and a registered fetch port.
// Optional per-word even parity with a parity_err output when PROG_MEM_PARITY_EN is defined.
module prog_mem #(
    parameter int unsigned INSTR_W = 16,
    parameter int unsigned DEPTH   = 256
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ld_start,
    input  logic                       ld_valid,
    input  logic [7:0]                 ld_byte,
    input  logic                       ld_last,
    output logic                       ld_ready,
    output logic                       ld_done,
    output logic                       ld_overflow,
    output logic [$clog2(DEPTH):0]     prog_len,
    input  logic                       fetch_en,
    input  logic [$clog2(DEPTH)-1:0]   fetch_addr,
    output logic [INSTR_W-1:0]         instr,
    output logic                       instr_valid
`ifdef PROG_MEM_PARITY_EN
   ,output logic                       parity_err
`endif
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned PW  = AW + 1;
    localparam int unsigned BPW = INSTR_W / 8;
    localparam int unsigned CW  = (BPW > 1) ? $clog2(BPW) : 1;
`ifdef PROG_MEM_PARITY_EN
    localparam int unsigned MW  = INSTR_W + 1;
`else
    localparam int unsigned MW  = INSTR_W;
`endif

    typedef enum logic {IDLE, LOAD} state_t;

    state_t             state, state_nx;
    logic [MW-1:0]      mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [CW-1:0]      byte_cnt;
    logic [INSTR_W-1:0] word_buf;

    logic               accept_c;
    logic               word_full_c;
    logic               do_write_c;
    logic               ptr_full_c;
    logic               mem_we_c;
    logic               fetch_go_c;
    logic [INSTR_W-1:0] word_nx_c;
    logic [MW-1:0]      rd_word_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (ld_start) state_nx = LOAD;
            LOAD: begin
                if (ld_start)                 state_nx = LOAD;
                else if (accept_c && ld_last) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // ld_start takes priority over a coincident byte, which is dropped
    assign accept_c    = ld_valid && (state == LOAD) && !ld_start;
    assign word_nx_c   = word_buf | (INSTR_W'(ld_byte) << {byte_cnt, 3'b000});
    assign word_full_c = (byte_cnt == CW'(BPW - 1));
    assign do_write_c  = accept_c && (word_full_c || ld_last);
    assign ptr_full_c  = (wr_ptr == PW'(DEPTH));
    assign mem_we_c    = do_write_c && !ptr_full_c;
    assign fetch_go_c  = (state == IDLE) && fetch_en && !ld_start;
    assign rd_word_c   = mem[fetch_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_ready    <= 1'b0;
            ld_done     <= 1'b0;
            ld_overflow <= 1'b0;
            prog_len    <= '0;
            wr_ptr      <= '0;
            byte_cnt    <= '0;
            word_buf    <= '0;
        end else begin
            ld_ready <= (state_nx == LOAD);
            ld_done  <= accept_c && ld_last;
            if (ld_start) begin
                wr_ptr      <= '0;
                byte_cnt    <= '0;
                word_buf    <= '0;
                ld_overflow <= 1'b0;
            end else if (accept_c) begin
                if (word_full_c || ld_last) begin
                    byte_cnt <= '0;
                    word_buf <= '0;
                end else begin
                    byte_cnt <= byte_cnt + CW'(1);
                    word_buf <= word_nx_c;
                end
                if (do_write_c) begin
                    if (ptr_full_c) ld_overflow <= 1'b1;
                    else            wr_ptr      <= wr_ptr + PW'(1);
                end
                // wr_ptr never passes DEPTH, so prog_len saturates there
                if (ld_last) prog_len <= wr_ptr + PW'(mem_we_c);
            end
        end
    end

    // Array is deliberately not reset; contents survive reset
    always_ff @(posedge clk) begin
`ifdef PROG_MEM_PARITY_EN
        if (mem_we_c) mem[wr_ptr[AW-1:0]] <= {^word_nx_c, word_nx_c};
`else
        if (mem_we_c) mem[wr_ptr[AW-1:0]] <= word_nx_c;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr       <= '0;
            instr_valid <= 1'b0;
`ifdef PROG_MEM_PARITY_EN
            parity_err  <= 1'b0;
`endif
        end else begin
            instr_valid <= fetch_go_c;
            if (fetch_go_c) begin
                instr <= rd_word_c[INSTR_W-1:0];
`ifdef PROG_MEM_PARITY_EN
                parity_err <= ^rd_word_c;
`endif
            end
        end
    end

endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem (INSTR_W=16, DEPTH=4): vector table plus scoreboarded fetches.
module tb_prog_mem;

    localparam int unsigned INSTR_W = 16;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned AW      = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               ld_start, ld_valid, ld_last;
    logic [7:0]         ld_byte;
    logic               ld_ready, ld_done, ld_overflow;
    logic [AW:0]        prog_len;
    logic               fetch_en;
    logic [AW-1:0]      fetch_addr;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
`ifdef PROG_MEM_PARITY_EN
    logic               parity_err;
`endif

    prog_mem #(.INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
        .ld_ready(ld_ready), .ld_done(ld_done), .ld_overflow(ld_overflow), .prog_len(prog_len),
        .fetch_en(fetch_en), .fetch_addr(fetch_addr), .instr(instr), .instr_valid(instr_valid)
`ifdef PROG_MEM_PARITY_EN
       ,.parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0]      addr;
        logic [INSTR_W-1:0] exp;
    } fvec_t;

    int                 cmp_cnt = 0;
    int                 err_cnt = 0;
    logic [INSTR_W-1:0] sb[$];
    bit                 mon_en = 1'b0;
    fvec_t              fv[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Fetch results are compared against the queue in issue order
    always @(negedge clk) begin
        if (mon_en && instr_valid) begin
            if (sb.size() == 0) begin
                cmp_cnt++;
                err_cnt++;
                $display("FAIL fetch_unexpected: got instr 0x%0h expected no result", instr);
            end else begin
                check("fetch_data", 32'(instr), 32'(sb.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("ready_after_start", 32'(ld_ready), 32'd1);
    endtask

    task automatic send(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_byte  = b;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch(input logic [AW-1:0] a, input logic [INSTR_W-1:0] exp);
        fetch_en   = 1'b1;
        fetch_addr = a;
        sb.push_back(exp);
        tick();
        fetch_en = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ld_start = 0; ld_valid = 0; ld_last = 0; ld_byte = 0;
        fetch_en = 0; fetch_addr = 0;
        fv[0] = '{2'd0, 16'h1234};
        fv[1] = '{2'd1, 16'h5678};
        fv[2] = '{2'd1, 16'h5678};
        fv[3] = '{2'd0, 16'h1234};

        #12;
        check("rst_ld_ready", 32'(ld_ready), 0);
        check("rst_ld_done", 32'(ld_done), 0);
        check("rst_overflow", 32'(ld_overflow), 0);
        check("rst_prog_len", 32'(prog_len), 0);
        check("rst_instr", 32'(instr), 0);
        check("rst_instr_valid", 32'(instr_valid), 0);
        reset = 1'b0;
        mon_en = 1'b1;
        tick();

        // Two full words
        start_load();
        send(8'h34, 0); send(8'h12, 0); send(8'h78, 0); send(8'h56, 1);
        check("done_pulse", 32'(ld_done), 1);
        check("ready_low_after_last", 32'(ld_ready), 0);
        check("prog_len_2", 32'(prog_len), 2);
        tick();
        check("done_one_cycle", 32'(ld_done), 0);
        foreach (fv[i]) fetch(fv[i].addr, fv[i].exp);
        tick();
        check("valid_drops", 32'(instr_valid), 0);
        check("instr_holds", 32'(instr), 32'h1234);

        // Partial final word is zero-filled
        start_load();
        send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 1);
        check("partial_prog_len", 32'(prog_len), 2);
        fetch(0, 16'hBBAA);
        fetch(1, 16'h00CC);

        // Overflow: 10 bytes into 4 words
        start_load();
        for (int i = 1; i <= 10; i++) send(8'(i), i == 10);
        check("ovf_set", 32'(ld_overflow), 1);
        check("ovf_prog_len", 32'(prog_len), 4);
        check("ovf_done", 32'(ld_done), 1);
        fetch(0, 16'h0201); fetch(1, 16'h0403); fetch(2, 16'h0605); fetch(3, 16'h0807);
        start_load();
        check("ovf_cleared", 32'(ld_overflow), 0);
        check("prog_len_kept", 32'(prog_len), 4);
        send(8'hEF, 0); send(8'hBE, 1);
        check("reload_prog_len", 32'(prog_len), 1);
        fetch(0, 16'hBEEF);

        // ld_start with ld_valid: byte dropped
        ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'h99;
        tick();
        ld_start = 1'b0; ld_valid = 1'b0;
        check("start_wins_ready", 32'(ld_ready), 1);
        send(8'h11, 0); send(8'h22, 1);
        check("start_wins_len", 32'(prog_len), 1);
        fetch(0, 16'h2211);

        // Restart mid-load clears byte counter and pointer
        start_load();
        send(8'h55, 0); send(8'h66, 0); send(8'h77, 0);
        start_load();
        send(8'h21, 0); send(8'h43, 1);
        check("restart_len", 32'(prog_len), 1);
        fetch(0, 16'h4321);
        fetch(1, 16'h0403);
        tick();

        // Fetch held high across a load
        mon_en = 1'b0;
        fetch_en = 1'b1; fetch_addr = 0;
        tick();
        check("hold_valid_idle", 32'(instr_valid), 1);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        check("hold_valid_load0", 32'(instr_valid), 0);
        send(8'h0D, 0);
        check("hold_valid_load1", 32'(instr_valid), 0);
        send(8'hF0, 1);
        check("hold_valid_at_done", 32'(instr_valid), 0);
        check("hold_done", 32'(ld_done), 1);
        tick();
        check("hold_valid_back", 32'(instr_valid), 1);
        check("hold_instr", 32'(instr), 32'hF00D);
        fetch_en = 1'b0;
        tick();
        mon_en = 1'b1;

        // Reset mid-load after 3 of 4 bytes
        start_load();
        send(8'hAB, 0); send(8'hCD, 0); send(8'hEF, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_ready", 32'(ld_ready), 0);
        check("mid_rst_done", 32'(ld_done), 0);
        check("mid_rst_ovf", 32'(ld_overflow), 0);
        check("mid_rst_len", 32'(prog_len), 0);
        check("mid_rst_instr", 32'(instr), 0);
        check("mid_rst_valid", 32'(instr_valid), 0);
        tick();
        reset = 1'b0;
        tick();
        fetch(0, 16'hCDAB);
        fetch(1, 16'h0403);
        tick();

`ifdef PROG_MEM_PARITY_EN
        mon_en = 1'b0;
        dut.mem[1][INSTR_W] = ~dut.mem[1][INSTR_W];
        fetch_en = 1'b1; fetch_addr = 1;
        tick();
        check("par_flip_valid", 32'(instr_valid), 1);
        check("par_flip_err", 32'(parity_err), 1);
        fetch_addr = 0;
        tick();
        fetch_en = 1'b0;
        check("par_ok_valid", 32'(instr_valid), 1);
        check("par_ok_err", 32'(parity_err), 0);
        tick();
`endif

        tick();
        check("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
